// File: rtl/exp_pkg.sv
// Shared definitions for the exponent adjust datapath: mode encodings,
// exception flag bundle and the default exponent bias.
package exp_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef struct packed {
    logic ovf;
    logic unf;
  } exp_flags_t;

  function automatic int default_bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/exp_adjust_core.sv
// Combinational exponent arithmetic: biased add/subtract of two exponents and
// saturation of a signed intermediate into the result exponent plus flags.
module exp_adjust_core
  import exp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int BIAS  = default_bias(EXP_W)
) (
  input  logic                      i_mode,
  input  logic        [EXP_W-1:0]   i_a,
  input  logic        [EXP_W-1:0]   i_b,
  input  logic signed [EXP_W+1:0]   i_s,
  output logic signed [EXP_W+1:0]   o_sum,
  output logic        [EXP_W-1:0]   o_exp,
  output exp_flags_t                o_flags
);

  localparam int S_W = EXP_W + 2;
  localparam logic signed [S_W-1:0] BIAS_S = S_W'(BIAS);
  localparam logic signed [S_W-1:0] S_MAX  = S_W'((2 ** EXP_W) - 1);
  localparam logic signed [S_W-1:0] S_ZERO = '0;

  logic signed [S_W-1:0] w_a_ext;
  logic signed [S_W-1:0] w_b_ext;

  // All-ones is reserved for infinity, so anything reaching it saturates there.
  function automatic logic [EXP_W-1:0] sat_exp(input logic signed [S_W-1:0] s);
    if (s >= S_MAX) begin
      return '1;
    end else if (s <= S_ZERO) begin
      return '0;
    end else begin
      return s[EXP_W-1:0];
    end
  endfunction

  function automatic exp_flags_t classify(input logic signed [S_W-1:0] s);
    exp_flags_t f;
    f.ovf = (s >= S_MAX);
    f.unf = (s <= S_ZERO);
    return f;
  endfunction

  assign w_a_ext = signed'({2'b00, i_a});
  assign w_b_ext = signed'({2'b00, i_b});

  always_comb begin
    if (i_mode == MODE_DIV) begin
      o_sum = w_a_ext - w_b_ext + BIAS_S;
    end else begin
      o_sum = w_a_ext + w_b_ext - BIAS_S;
    end
  end

  assign o_exp   = sat_exp(i_s);
  assign o_flags = classify(i_s);

endmodule

// File: rtl/exp_adjust_pipe.sv
// Two-stage exponent adjuster with valid/ready handshake and sticky/counted
// overflow and underflow status, sitting between unpack and normalise.
module exp_adjust_pipe
  import exp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int BIAS  = default_bias(EXP_W),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [EXP_W-1:0]   in_a,
  input  logic [EXP_W-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_ovf,
  output logic               out_unf,
  input  logic               clr_status,
  output logic               sticky_ovf,
  output logic               sticky_unf,
  output logic [CNT_W-1:0]   ovf_count,
  output logic [CNT_W-1:0]   unf_count
);

  localparam int S_W = EXP_W + 2;

  logic                  w_s1_load;
  logic                  w_s2_load;
  logic                  w_xfer;
  logic                  w_ovf_evt;
  logic                  w_unf_evt;
  logic signed [S_W-1:0] w_sum;
  logic [EXP_W-1:0]      w_exp_sat;
  exp_flags_t            w_flags;

  logic                  r_vld_p1;
  logic signed [S_W-1:0] r_s_p1;
  logic                  r_vld_p2;
  logic [EXP_W-1:0]      r_exp_p2;
  exp_flags_t            r_flags_p2;
  logic                  r_sticky_ovf;
  logic                  r_sticky_unf;
  logic [CNT_W-1:0]      r_ovf_cnt;
  logic [CNT_W-1:0]      r_unf_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base,
                                               input logic             ev);
    if (ev && (base != '1)) begin
      return base + 1'b1;
    end else begin
      return base;
    end
  endfunction

  exp_adjust_core #(
    .EXP_W (EXP_W),
    .BIAS  (BIAS)
  ) u_core (
    .i_mode  (in_mode),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_s     (r_s_p1),
    .o_sum   (w_sum),
    .o_exp   (w_exp_sat),
    .o_flags (w_flags)
  );

  // The ready chain runs backwards combinationally, giving full throughput and
  // letting in_ready rise in the same cycle as out_ready.
  assign w_s2_load = !r_vld_p2 || out_ready;
  assign w_s1_load = !r_vld_p1 || w_s2_load;
  assign in_ready  = w_s1_load;
  assign w_xfer    = r_vld_p2 && out_ready;
  assign w_ovf_evt = w_xfer && r_flags_p2.ovf;
  assign w_unf_evt = w_xfer && r_flags_p2.unf;

  // Stage 1: signed intermediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_load) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_load && in_valid) begin
      r_s_p1 <= w_sum;
    end
  end

  // Stage 2: classified, saturated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_exp_p2   <= '0;
      r_flags_p2 <= '0;
    end else if (w_s2_load) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_exp_p2   <= w_exp_sat;
        r_flags_p2 <= w_flags;
      end
    end
  end

  // A clear coinciding with an event still records that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
      r_sticky_unf <= 1'b0;
      r_ovf_cnt    <= '0;
      r_unf_cnt    <= '0;
    end else begin
      r_sticky_ovf <= (clr_status ? 1'b0 : r_sticky_ovf) | w_ovf_evt;
      r_sticky_unf <= (clr_status ? 1'b0 : r_sticky_unf) | w_unf_evt;
      r_ovf_cnt    <= sat_inc(clr_status ? '0 : r_ovf_cnt, w_ovf_evt);
      r_unf_cnt    <= sat_inc(clr_status ? '0 : r_unf_cnt, w_unf_evt);
    end
  end

  assign out_valid  = r_vld_p2;
  assign out_exp    = r_exp_p2;
  assign out_ovf    = r_flags_p2.ovf;
  assign out_unf    = r_flags_p2.unf;
  assign sticky_ovf = r_sticky_ovf;
  assign sticky_unf = r_sticky_unf;
  assign ovf_count  = r_ovf_cnt;
  assign unf_count  = r_unf_cnt;

endmodule

// File: doc/exp_adjust_pipe.md
# exp_adjust_pipe

Pipelined, parametrised exponent adjuster for the fused multiply/divide datapath. It adds biased exponents in multiply mode (a + b − BIAS) or subtracts them in divide mode (a − b + BIAS). Results are classified as overflow or underflow and saturated. It replaces the flat combinational exponent subtractor, adding bias handling, a mode select, a valid/ready handshake and sticky/counted exception status. It sits between operand unpacking and the normaliser.

## Interface
Parameters:
- EXP_W, 8: exponent field width.
- BIAS, 2**(EXP_W-1)-1: exponent bias. Must be < 2**EXP_W.
- CNT_W, 16: width of the exception event counters.

Ports (clock and reset first). The block uses one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_mode  in  1  0 = multiply (a+b−BIAS), 1 = divide (a−b+BIAS).
- in_a  in  EXP_W  biased exponent A, unsigned.
- in_b  in  EXP_W  biased exponent B, unsigned.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_exp  out  EXP_W  saturated result exponent.
- out_ovf  out  1  the result overflowed; out_exp is all-ones.
- out_unf  out  1  the result underflowed; out_exp is 0.
- clr_status  in  1  synchronous clear of the sticky flags and counters.
- sticky_ovf  out  1  an overflow beat has been delivered since the last clear.
- sticky_unf  out  1  an underflow beat has been delivered since the last clear.
- ovf_count  out  CNT_W  number of overflow beats delivered; saturates at all-ones.
- unf_count  out  CNT_W  number of underflow beats delivered; saturates at all-ones.

## Operation
Stage 1 (S1) registers a signed intermediate s of width EXP_W+2, together with a valid bit.
- Multiply mode: s = a + b − BIAS.
- Divide mode: s = a − b + BIAS.
- All operands are zero-extended before the operation, so s never wraps.

Stage 2 (S2) classifies s and registers the outputs.
- s ≥ 2**EXP_W − 1: overflow. out_exp = all-ones (reserved for infinity), out_ovf = 1.
- s ≤ 0: underflow. out_exp = 0, out_unf = 1.
- Otherwise: out_exp = s[EXP_W−1:0] and both flags are 0.
- The boundaries for EXP_W=8 are: s=254 passes with no flag, s=255 overflows, s=1 passes, s=0 underflows.

Handshake rules:
- A beat transfers on an interface when valid and ready are both high in the same cycle.
- S2 loads when S2 is empty or out_ready is high.
- S1 loads when S1 is empty or S2 loads.
- in_ready = !s1_valid || s2_load. This is a combinational path from out_ready to in_ready, which is permitted.
- out_valid does not depend combinationally on out_ready.
- Once out_valid is high, out_exp, out_ovf and out_unf stay stable until the beat transfers.

Status:
- The sticky flags and counters update only on an output transfer (out_valid && out_ready).
- Each sticky flag follows: next = (clr_status ? 0 : current) | event_this_cycle. When a clear and an event coincide, the result is 1.
- Each counter follows: next = (clr_status ? 0 : count) + event_this_cycle, saturating at all-ones. When a clear and an event coincide, the result is 1.

Reset, asynchronous and allowed mid-operation:
- Both stage valids clear to 0, so in-flight beats are discarded.
- out_valid=0, out_exp=0, out_ovf=0, out_unf=0.
- sticky flags = 0 and both counters = 0.
- in_ready is 1 in the first cycle after reset deasserts.

## Timing
- Latency: a beat accepted at edge N presents out_valid at edge N+2 when there is no backpressure.
- Throughput: one beat per cycle while out_ready is held high.
- Capacity: two beats. With out_ready low, the block accepts two beats and then in_ready drops.
- Backpressure: no beat is lost or duplicated, and output order equals input order.
- Out_ready release: in_ready rises in the same cycle that out_ready rises.
- Status lag: the sticky flags and counters reflect a delivered beat from the cycle after its transfer.

## Structure
- Shared package exp_pkg holds:
  - MODE_MUL = 1'b0 and MODE_DIV = 1'b1;
  - a packed flag struct {ovf, unf};
  - a function that computes the default bias from EXP_W.
- Sub-module exp_adjust_core is purely combinational. It takes mode, a, b and s and produces the S1 sum and the S2 classification/saturation, and is reused by the divider.
- The top level contains the two pipeline stages, the handshake logic and the status registers.

## Test plan
All scenarios use EXP_W=8, BIAS=127.
- Multiply 130,131: out_exp=134, no flags, out_valid exactly 2 cycles after acceptance.
- Multiply 200,200 → out_exp=255 with out_ovf=1. Multiply 10,20 → out_exp=0 with out_unf=1. sticky_ovf=1, sticky_unf=1 and each counter = 1 afterwards.
- Divide 127,127 → 127. Divide 10,200 → 0 with out_unf=1. Divide 250,1 → 255 with out_ovf=1. Boundaries: divide 127,0 → 254 with no flag; divide 128,0 → 255 with out_ovf=1.
- Backpressure: hold out_ready=0 and offer 3 beats. Only 2 are accepted and in_ready=0. After releasing out_ready, the 3 results arrive in order and out_exp stays stable while stalled.
- Assert clr_status in the same cycle as an overflow beat transfers: sticky_ovf=1 and ovf_count=1. A clear in a later idle cycle gives 0 for both.
- Assert rst_n low with 2 beats in flight: out_valid=0 immediately and all status = 0. After release, a new beat completes normally with 2-cycle latency.
